ha_array_accumulator: RTL



---
 rtl/ha_array_accumulator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ha_array_accumulator.sv
// Accumulates the four compressed half-adder-array rows of an 8x8 multiplier,
// one row per cycle, and returns the product over a valid/ready handshake.
module ha_array_accumulator #(
    parameter int ROWS      = 4,
    parameter int T_W       = 9,
    parameter int B_W       = 7,
    parameter int B_OFS     = 2,
    parameter int ROW_SHIFT = 2,
    parameter int P_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROWS*T_W-1:0] in_t,
    input  logic [ROWS*B_W-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_W-1:0]      product,
    output logic                ovf
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ROWS*T_W-1:0]  t_q, t_d;
    logic [ROWS*B_W-1:0]  b_q, b_d;
    logic [P_W-1:0]       acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;

    logic [T_W-1:0]       t_sel;
    logic [B_W-1:0]       b_sel;
    logic [P_W:0]         row_raw;
    logic [P_W:0]         row_val;
    logic [P_W:0]         sum;

    // Weighted value of the row selected by the counter, carried at P_W+1 bits.
    always_comb begin
        t_sel   = t_q[cnt_q*T_W +: T_W];
        b_sel   = b_q[cnt_q*B_W +: B_W];
        row_raw = (P_W+1)'(t_sel) + ((P_W+1)'(b_sel) << B_OFS);
        row_val = row_raw << (cnt_q * ROW_SHIFT);
        sum     = {1'b0, acc_q} + row_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        b_d         = b_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    t_d     = in_t;
                    b_d     = in_b;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = sum[P_W-1:0];
                ovf_d = ovf_q | sum[P_W];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ROW) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        product   = acc_q;
        ovf       = ovf_q;
    end

endmodule
